// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: MIPS decode-stage immediate, branch/jump target and class generator.
// Latency: DEPTH register stages; a beat accepted at edge N is valid after edge N+DEPTH-1.
// Backpressure: elastic valid/ready per stage; in_ready_O drops only when all stages hold data and out_ready_I is low.
module imm_gen_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk_I,
  input  logic              rst_n_I,
  input  logic              flush_I,
  input  logic              in_valid_I,
  output logic              in_ready_O,
  input  logic [5:0]        op_I,
  input  logic [25:0]       instr_I,
  input  logic [DATA_W-1:0] pc_I,
  output logic              out_valid_O,
  input  logic              out_ready_I,
  output logic [DATA_W-1:0] imm_O,
  output logic [DATA_W-1:0] target_O,
  output logic [2:0]        kind_O
);

  typedef enum logic [2:0] {
    K_ZEXT   = 3'd0,
    K_SEXT   = 3'd1,
    K_LUI    = 3'd2,
    K_BRANCH = 3'd3,
    K_JUMP   = 3'd4
  } kind_e;

  logic [15:0]       imm16;
  kind_e             kind_c;
  logic [DATA_W-1:0] sext_c;
  logic [DATA_W-1:0] pcp4_c;
  logic [DATA_W-1:0] imm_c;
  logic [DATA_W-1:0] tgt_c;

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;
  logic [DEPTH-1:0]  ld;
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [DATA_W-1:0] imm_d  [DEPTH];
  logic [DATA_W-1:0] tgt_q  [DEPTH];
  logic [DATA_W-1:0] tgt_d  [DEPTH];
  logic [2:0]        kind_q [DEPTH];
  logic [2:0]        kind_d [DEPTH];

  assign imm16 = instr_I[15:0];

  // Opcode to class; anything with op[5] set is a load/store and takes a signed offset
  always_comb begin
    kind_c = K_ZEXT;
    case (op_I)
      6'b000001, 6'b000100, 6'b000101,
      6'b000110, 6'b000111:             kind_c = K_BRANCH;
      6'b000010, 6'b000011:             kind_c = K_JUMP;
      6'b001111:                        kind_c = K_LUI;
      6'b001000, 6'b001001,
      6'b001010, 6'b001011:             kind_c = K_SEXT;
      default:                          kind_c = op_I[5] ? K_SEXT : K_ZEXT;
    endcase
  end

  // Immediate and target arithmetic, all ahead of stage 0 so later stages only carry results
  always_comb begin
    sext_c = {{(DATA_W-16){imm16[15]}}, imm16};
    pcp4_c = pc_I + DATA_W'(4);
    imm_c  = '0;
    tgt_c  = pcp4_c;
    case (kind_c)
      K_ZEXT:   imm_c = {{(DATA_W-16){1'b0}}, imm16};
      K_SEXT:   imm_c = sext_c;
      // Shifting the sign-extended value gives the upper sign fill for 64-bit and drops it for 32-bit
      K_LUI:    imm_c = sext_c << 16;
      K_BRANCH: begin
        imm_c = sext_c;
        tgt_c = pcp4_c + (sext_c << 2);
      end
      K_JUMP:   begin
        imm_c[27:0] = {instr_I, 2'b00};
        tgt_c       = {pcp4_c[DATA_W-1:28], instr_I, 2'b00};
      end
      default:  imm_c = '0;
    endcase
  end

  // A stage loads when it, or any stage downstream of it, has room, or when the consumer takes the head
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      ld[s] = out_ready_I;
      for (int t = s; t < DEPTH; t++) begin
        if (!vld_q[t]) ld[s] = 1'b1;
      end
    end
  end

  // Next-state of each stage: shift on load, data only moves with a valid beat, flush kills all valids
  always_comb begin
    vld_d = vld_q;
    for (int s = 0; s < DEPTH; s++) begin
      imm_d[s]  = imm_q[s];
      tgt_d[s]  = tgt_q[s];
      kind_d[s] = kind_q[s];
    end
    if (ld[0]) begin
      vld_d[0] = in_valid_I;
      if (in_valid_I) begin
        imm_d[0]  = imm_c;
        tgt_d[0]  = tgt_c;
        kind_d[0] = kind_c;
      end
    end
    for (int s = 1; s < DEPTH; s++) begin
      if (ld[s]) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) begin
          imm_d[s]  = imm_q[s-1];
          tgt_d[s]  = tgt_q[s-1];
          kind_d[s] = kind_q[s-1];
        end
      end
    end
    if (flush_I) vld_d = '0;
  end

  // Stage registers; reset clears valids and data so idle outputs read as zero
  always_ff @(posedge clk_I) begin
    if (!rst_n_I) begin
      vld_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        imm_q[s]  <= '0;
        tgt_q[s]  <= '0;
        kind_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < DEPTH; s++) begin
        imm_q[s]  <= imm_d[s];
        tgt_q[s]  <= tgt_d[s];
        kind_q[s] <= kind_d[s];
      end
    end
  end

  assign in_ready_O  = ld[0];
  assign out_valid_O = vld_q[DEPTH-1];
  assign imm_O       = imm_q[DEPTH-1];
  assign target_O    = tgt_q[DEPTH-1];
  assign kind_O      = kind_q[DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe (32-bit/DEPTH=3 and 64-bit/DEPTH=1 instances).
// Latency: expectations queued on input handshake, compared on output handshake.
// Backpressure: exercises stalls, flush and reset with beats in flight.
module tb_imm_gen_pipe;

  localparam int DW_A    = 32;
  localparam int DEPTH_A = 3;
  localparam int DW_B    = 64;
  localparam int DEPTH_B = 1;

  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] imm;
    logic [63:0] tgt;
  } res_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [25:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [2:0]  kind;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            out_ready_a;
  logic [5:0]      op;
  logic [25:0]     instr;
  logic [31:0]     pc;
  logic [63:0]     pc_b;
  logic            in_ready_a, out_valid_a;
  logic [DW_A-1:0] imm_a, tgt_a;
  logic [2:0]      kind_a;
  logic            in_ready_b, out_valid_b;
  logic [DW_B-1:0] imm_b, tgt_b;
  logic [2:0]      kind_b;

  assign pc_b = {~pc, pc};

  int   n_chk = 0;
  int   n_err = 0;
  int   acc_a = 0;
  res_t q_a[$];
  res_t q_b[$];
  res_t exp_a;
  vec_t vecs[12];
  bit   stop_rnd;

  imm_gen_pipe #(.DATA_W(DW_A), .DEPTH(DEPTH_A)) u_dut_a (
    .clk_I(clk), .rst_n_I(rst_n), .flush_I(flush),
    .in_valid_I(in_valid), .in_ready_O(in_ready_a),
    .op_I(op), .instr_I(instr), .pc_I(pc),
    .out_valid_O(out_valid_a), .out_ready_I(out_ready_a),
    .imm_O(imm_a), .target_O(tgt_a), .kind_O(kind_a)
  );

  imm_gen_pipe #(.DATA_W(DW_B), .DEPTH(DEPTH_B)) u_dut_b (
    .clk_I(clk), .rst_n_I(rst_n), .flush_I(flush),
    .in_valid_I(in_valid), .in_ready_O(in_ready_b),
    .op_I(op), .instr_I(instr), .pc_I(pc_b),
    .out_valid_O(out_valid_b), .out_ready_I(1'b1),
    .imm_O(imm_b), .target_O(tgt_b), .kind_O(kind_b)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, want);
    end
  endtask

  // Reference: 64-bit result; the 32-bit instance compares the low half
  function automatic res_t model(input logic [5:0] o, input logic [25:0] ins, input logic [63:0] p);
    res_t        r;
    logic [63:0] sx, p4;
    sx    = {{48{ins[15]}}, ins[15:0]};
    p4    = p + 64'd4;
    r.tgt = p4;
    r.imm = '0;
    case (o)
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: r.kind = 3'd3;
      6'h02, 6'h03:                      r.kind = 3'd4;
      6'h0F:                             r.kind = 3'd2;
      6'h08, 6'h09, 6'h0A, 6'h0B:        r.kind = 3'd1;
      default:                           r.kind = o[5] ? 3'd1 : 3'd0;
    endcase
    case (r.kind)
      3'd0: r.imm = {48'b0, ins[15:0]};
      3'd1: r.imm = sx;
      3'd2: r.imm = {sx[47:0], 16'b0};
      3'd3: begin r.imm = sx; r.tgt = p4 + {sx[61:0], 2'b00}; end
      default: begin r.imm = {36'b0, ins, 2'b00}; r.tgt = {p4[63:28], ins, 2'b00}; end
    endcase
    return r;
  endfunction

  // Scoreboard: pop/compare on output handshakes, push on input handshakes, drop all on flush/reset
  always @(negedge clk) begin
    res_t e;
    if (out_valid_a === 1'b1 && out_ready_a) begin
      chk("a_avail", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_imm",  64'(imm_a),  {32'b0, e.imm[31:0]});
        chk("a_tgt",  64'(tgt_a),  {32'b0, e.tgt[31:0]});
        chk("a_kind", 64'(kind_a), 64'(e.kind));
      end
    end
    if (out_valid_b === 1'b1) begin
      chk("b_avail", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_imm",  imm_b,        e.imm);
        chk("b_tgt",  tgt_b,        e.tgt);
        chk("b_kind", 64'(kind_b),  64'(e.kind));
      end
    end
    if (rst_n && !flush && in_valid) begin
      if (in_ready_a) begin
        q_a.push_back(exp_a);
        acc_a++;
      end
      if (in_ready_b) q_b.push_back(model(op, instr, pc_b));
    end
    if (!rst_n || flush) begin
      q_a.delete();
      q_b.delete();
    end
  end

  task automatic send(input logic [5:0] o, input logic [25:0] ins, input logic [31:0] p, input res_t e);
    logic ok;
    ok       = 1'b0;
    op       = o;
    instr    = ins;
    pc       = p;
    exp_a    = e;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready_a && rst_n && !flush;
      @(posedge clk);
      #1;
    end
    chk("send_acc", 64'(ok), 64'd1);
  endtask

  task automatic send_rand();
    logic [5:0]  o;
    logic [25:0] ins;
    logic [31:0] p;
    o   = 6'($urandom_range(0, 63));
    ins = 26'($urandom());
    p   = $urandom();
    if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFFC;
    send(o, ins, p, model(o, ins, {32'b0, p}));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("a_drained", 64'(q_a.size()), 64'd0);
    chk("b_drained", 64'(q_b.size()), 64'd0);
    @(posedge clk);
    #1;
    chk("a_idle", 64'(out_valid_a), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        e;
    int          lat;
    logic [31:0] s_imm, s_tgt;
    logic [2:0]  s_kind;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready_a = 1'b1;
    op = '0; instr = '0; pc = '0; exp_a = '0; stop_rnd = 1'b0;

    //          op      instr         pc            imm           target        kind
    vecs[0]  = '{6'h08, 26'h2958000, 32'h0000_0100, 32'hFFFF_8000, 32'h0000_0104, 3'd1}; // ADDI
    vecs[1]  = '{6'h0D, 26'h0008000, 32'h0000_0200, 32'h0000_8000, 32'h0000_0204, 3'd0}; // ORI
    vecs[2]  = '{6'h23, 26'h000FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0004, 3'd1}; // LW
    vecs[3]  = '{6'h0F, 26'h0001234, 32'h0000_0300, 32'h1234_0000, 32'h0000_0304, 3'd2}; // LUI
    vecs[4]  = '{6'h04, 26'h000FFFF, 32'h0040_0010, 32'hFFFF_FFFF, 32'h0040_0010, 3'd3}; // BEQ
    vecs[5]  = '{6'h05, 26'h0000001, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0004, 3'd3}; // BNE wrap
    vecs[6]  = '{6'h02, 26'h0100000, 32'h1000_0000, 32'h0040_0000, 32'h1040_0000, 3'd4}; // J
    vecs[7]  = '{6'h03, 26'h3FFFFFF, 32'hF000_0000, 32'h0FFF_FFFC, 32'hFFFF_FFFC, 3'd4}; // JAL
    vecs[8]  = '{6'h01, 26'h0000010, 32'h0000_1000, 32'h0000_0010, 32'h0000_1044, 3'd3}; // REGIMM
    vecs[9]  = '{6'h2B, 26'h0000008, 32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 3'd1}; // SW
    vecs[10] = '{6'h0C, 26'h000FFFF, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_0004, 3'd0}; // ANDI
    vecs[11] = '{6'h0F, 26'h0008000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0004, 3'd2}; // LUI 0x8000

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vld",   64'(out_valid_a), 64'd0);
    chk("rst_imm",   64'(imm_a),       64'd0);
    chk("rst_tgt",   64'(tgt_a),       64'd0);
    chk("rst_kind",  64'(kind_a),      64'd0);
    chk("rst_rdy",   64'(in_ready_a),  64'd1);
    chk("rst_b_vld", 64'(out_valid_b), 64'd0);
    @(posedge clk);
    #1;

    // Directed table, streamed back to back
    for (int i = 0; i < 12; i++) begin
      e = '{kind: vecs[i].kind, imm: 64'(vecs[i].imm), tgt: 64'(vecs[i].tgt)};
      send(vecs[i].op, vecs[i].ins, vecs[i].pc, e);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b_lui_vld", 64'(out_valid_b), 64'd1);
    chk("b_lui_imm", imm_b,            64'hFFFF_FFFF_8000_0000);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: 5 beats against a stalled consumer
    out_ready_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand();
        in_valid = 1'b0;
      end
      begin
        int c0;
        c0 = acc_a;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_acc", 64'(acc_a - c0),  64'd3);
        chk("bp_rdy", 64'(in_ready_a),  64'd0);
        chk("bp_vld", 64'(out_valid_a), 64'd1);
        s_imm = imm_a; s_tgt = tgt_a; s_kind = kind_a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_hold_imm",  64'(imm_a),  64'(s_imm));
        chk("bp_hold_tgt",  64'(tgt_a),  64'(s_tgt));
        chk("bp_hold_kind", 64'(kind_a), 64'(s_kind));
        @(posedge clk);
        #1 out_ready_a = 1'b1;
      end
    join
    drain();

    // Flush a full pipe with a coincident input beat
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_rdy", 64'(in_ready_a),  64'd0);
    chk("full_vld", 64'(out_valid_a), 64'd1);
    @(posedge clk);
    #1;
    out_ready_a = 1'b1; flush = 1'b1;
    op = 6'h0F; instr = 26'h000ABCD; pc = 32'h0000_4000;
    exp_a = model(op, instr, {32'b0, pc});
    in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_vld",   64'(out_valid_a), 64'd0);
    chk("flush_b_vld", 64'(out_valid_b), 64'd0);
    @(posedge clk);
    #1;
    send_rand();
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid_a && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("flush_lat", 64'(lat), 64'(DEPTH_A - 1));
    @(posedge clk);
    #1;
    drain();

    // Reset with the pipe full
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_vld",   64'(out_valid_a), 64'd0);
    chk("mrst_imm",   64'(imm_a),       64'd0);
    chk("mrst_tgt",   64'(tgt_a),       64'd0);
    chk("mrst_kind",  64'(kind_a),      64'd0);
    chk("mrst_rdy",   64'(in_ready_a),  64'd1);
    chk("mrst_b_vld", 64'(out_valid_b), 64'd0);
    @(posedge clk);
    #1;
    out_ready_a = 1'b1;

    // Random traffic with random bubbles and consumer stalls
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        in_valid = 1'b0;
        stop_rnd = 1'b1;
      end
      begin
        while (!stop_rnd) begin
          @(posedge clk);
          #1 out_ready_a = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready_a = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
